// File: rtl/heap_control.sv
// Max-heap engine over an internal register array: make_heap, push and pop,
// with the array streamed out on arr_out/index after each operation.
module heap_control #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              op,
    output logic              done,
    output logic [DATA_W-1:0] arr_out,
    output logic [ADDR_W-1:0] n,
    output logic [ADDR_W-1:0] index
);
    localparam int unsigned CAP = (1 << ADDR_W) - 1;
    localparam int unsigned IW  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        SIFT_DOWN,
        SIFT_UP,
        DONE
    } state_t;

    state_t state, state_d;

    logic [DATA_W-1:0] arr [0:CAP-1];

    logic [IW-1:0]     cur, cur_d;
    logic [ADDR_W-1:0] bi, bi_d;
    logic              bld, bld_d;
    logic              built, built_d;
    logic [ADDR_W-1:0] n_d;
    logic [ADDR_W-1:0] index_d;

    logic              sw_en;
    logic              ins_en;
    logic [ADDR_W-1:0] sw_a, sw_b;

    // Tree navigation; IW bits keep 2*cur+2 from overflowing.
    logic [IW-1:0]     n_ext, lc, rc, big;
    logic [ADDR_W-1:0] cur_a, par;
    logic [DATA_W-1:0] v_cur, v_l, v_r, v_p, big_v;

    assign n_ext = {1'b0, n};
    assign lc    = (cur << 1) + IW'(1);
    assign rc    = (cur << 1) + IW'(2);
    assign cur_a = cur[ADDR_W-1:0];
    assign par   = ADDR_W'((cur - IW'(1)) >> 1);
    assign v_cur = arr[cur_a];
    assign v_l   = arr[lc[ADDR_W-1:0]];
    assign v_r   = arr[rc[ADDR_W-1:0]];
    assign v_p   = arr[par];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        cur_d   = cur;
        bi_d    = bi;
        bld_d   = bld;
        built_d = built;
        n_d     = n;
        sw_en   = 1'b0;
        sw_a    = '0;
        sw_b    = '0;
        ins_en  = 1'b0;
        big     = cur;
        big_v   = v_cur;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (!built) begin
                        // First request after reset heapifies the preloaded contents.
                        built_d = 1'b1;
                        bld_d   = 1'b1;
                        if (n <= ADDR_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            bi_d    = (n >> 1) - ADDR_W'(1);
                            state_d = BUILD;
                        end
                    end else if (!op) begin
                        bld_d = 1'b0;
                        if (n == ADDR_W'(CAP)) begin
                            state_d = DONE;
                        end else begin
                            ins_en  = 1'b1;
                            n_d     = n + ADDR_W'(1);
                            cur_d   = IW'(n);
                            state_d = SIFT_UP;
                        end
                    end else begin
                        bld_d = 1'b0;
                        if (n == '0) begin
                            state_d = DONE;
                        end else begin
                            // Removed maximum parks just past the shrunken heap.
                            sw_en   = 1'b1;
                            sw_a    = '0;
                            sw_b    = n - ADDR_W'(1);
                            n_d     = n - ADDR_W'(1);
                            cur_d   = '0;
                            state_d = SIFT_DOWN;
                        end
                    end
                end
            end

            BUILD: begin
                cur_d   = IW'(bi);
                state_d = SIFT_DOWN;
            end

            SIFT_DOWN: begin
                if (lc < n_ext && v_l > big_v) begin
                    big   = lc;
                    big_v = v_l;
                end
                if (rc < n_ext && v_r > big_v) begin
                    big = rc;
                end
                if (big != cur) begin
                    sw_en = 1'b1;
                    sw_a  = cur_a;
                    sw_b  = big[ADDR_W-1:0];
                    cur_d = big;
                end else if (bld && bi != '0) begin
                    bi_d    = bi - ADDR_W'(1);
                    state_d = BUILD;
                end else begin
                    state_d = DONE;
                end
            end

            SIFT_UP: begin
                if (cur != '0 && v_p < v_cur) begin
                    sw_en = 1'b1;
                    sw_a  = cur_a;
                    sw_b  = par;
                    cur_d = IW'(par);
                end else begin
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Stream pointer restarts on every entry into DONE and wraps at n-1.
    always_comb begin
        index_d = '0;
        if (state_d == DONE && state == DONE && !start) begin
            if (n == '0 || index >= n - ADDR_W'(1)) begin
                index_d = '0;
            end else begin
                index_d = index + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            n       <= '0;
            cur     <= '0;
            bi      <= '0;
            bld     <= 1'b0;
            built   <= 1'b0;
            done    <= 1'b0;
            index   <= '0;
            arr_out <= '0;
        end else begin
            n       <= n_d;
            cur     <= cur_d;
            bi      <= bi_d;
            bld     <= bld_d;
            built   <= built_d;
            done    <= (state_d == DONE);
            index   <= index_d;
            arr_out <= (state_d == DONE) ? arr[index_d] : '0;
        end
    end

    // Array storage is not cleared by reset, but reset suppresses writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (ins_en) begin
                arr[n] <= key;
            end
            if (sw_en) begin
                arr[sw_a] <= arr[sw_b];
                arr[sw_b] <= arr[sw_a];
            end
        end
    end

endmodule

// File: tb/tb_heap_control.sv
// Scoreboard bench for heap_control: the driver queues expected stream entries
// per operation and a negedge monitor compares them while done is high.
module tb_heap_control;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] key;
    logic              op;
    logic              done;
    logic [DATA_W-1:0] arr_out;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] index;

    always #5 clk = ~clk;

    heap_control #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .key     (key),
        .op      (op),
        .done    (done),
        .arr_out (arr_out),
        .n       (n),
        .index   (index)
    );

    typedef struct {
        int unsigned idx;
        logic [31:0] val;
        bit          cv;
        int unsigned nn;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        stage_q[$];
    logic [31:0] model[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] init1 [0:9]  = '{10, 20, 5, 6, 1, 8, 9, 4, 7, 2};
    logic [31:0] heap1 [0:9]  = '{20, 10, 9, 7, 2, 8, 5, 4, 6, 1};
    logic [31:0] heap2 [0:10] = '{20, 15, 9, 7, 10, 8, 5, 4, 6, 1, 2};
    logic [31:0] heap3 [0:9]  = '{15, 10, 9, 7, 2, 8, 5, 4, 6, 1};
    logic [31:0] ktab  [0:7]  = '{0, 1, 7, 7, 15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic exp_val(input int unsigned i, input logic [31:0] v, input int unsigned nn);
        stage_q.push_back('{idx: i, val: v, cv: 1'b1, nn: nn});
    endtask

    task automatic exp_dc(input int unsigned i, input int unsigned nn);
        stage_q.push_back('{idx: i, val: 32'h0, cv: 1'b0, nn: nn});
    endtask

    function automatic logic [31:0] model_max();
        logic [31:0] m = 32'h0;
        foreach (model[i]) if (model[i] > m) m = model[i];
        return m;
    endfunction

    // Monitor: one expected stream entry per cycle spent in DONE.
    exp_t e;
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stream index", 64'(index), 64'(e.idx));
            check("stream n", 64'(n), 64'(e.nn));
            if (e.cv) check("stream arr_out", 64'(arr_out), 64'(e.val));
        end
    end

    task automatic run_op(input string nm, input logic op_v, input logic [31:0] k,
                          input int bound, input bit poke);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        op    = op_v;
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (stage_q.size() > 0) exp_q.push_back(stage_q.pop_front());
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (poke && done !== 1'b1 && (cyc == 2 || cyc == 4)) begin
                start = 1'b1;
                op    = ~op_v;
                key   = 32'hDEAD;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done: not seen after %0d cycles, required within %0d", nm, cyc, bound);
        end else if (cyc > bound) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required <= %0d", nm, cyc, bound);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL %s stream: %0d entries unchecked, required 0", nm, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        key   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done", 64'(done), 64'(0));
        check("reset n", 64'(n), 64'(0));
        check("reset index", 64'(index), 64'(0));
        check("reset arr_out", 64'(arr_out), 64'(0));
        reset = 1'b1;

        // make_heap from preload, op ignored, busy-time starts ignored
        @(negedge clk);
        for (int i = 0; i < 10; i++) dut.arr[i] <= init1[i];
        dut.n <= 10'd10;
        for (int i = 0; i < 10; i++) exp_val(i, heap1[i], 10);
        exp_val(0, heap1[0], 10);
        run_op("make_heap", 1'b1, 32'hAAAA, 44, 1'b1);

        for (int i = 0; i < 11; i++) exp_val(i, heap2[i], 11);
        exp_val(0, heap2[0], 11);
        run_op("push 15", 1'b0, 32'd15, 24, 1'b0);

        for (int i = 0; i < 10; i++) exp_val(i, heap3[i], 10);
        exp_val(0, heap3[0], 10);
        run_op("pop", 1'b1, 32'h0, 24, 1'b0);
        check("popped max arr[10]", 64'(dut.arr[10]), 64'(20));

        // push into a full heap is a no-op
        @(negedge clk);
        dut.n <= 10'd1023;
        for (int i = 0; i < 5; i++) exp_val(i, heap3[i], 1023);
        run_op("push full", 1'b0, 32'd99, 24, 1'b0);
        check("full arr[10] kept", 64'(dut.arr[10]), 64'(20));

        // reset aborts a make_heap in progress
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) dut.arr[i] <= init1[i];
        dut.n <= 10'd10;
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy done", 64'(done), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("abort done", 64'(done), 64'(0));
        check("abort n", 64'(n), 64'(0));
        check("abort index", 64'(index), 64'(0));
        check("abort arr_out", 64'(arr_out), 64'(0));
        reset = 1'b1;

        exp_dc(0, 0);
        exp_dc(0, 0);
        run_op("make_heap n0", 1'b1, 32'h0, 8, 1'b0);

        exp_dc(0, 0);
        exp_dc(0, 0);
        exp_dc(0, 0);
        run_op("pop empty", 1'b1, 32'h0, 24, 1'b0);

        // equal keys: no swap
        @(negedge clk);
        dut.arr[0] <= 32'd5;
        dut.n <= 10'd1;
        exp_val(0, 5, 2);
        exp_val(1, 5, 2);
        exp_val(0, 5, 2);
        run_op("push tie", 1'b0, 32'd5, 24, 1'b0);

        // mixed push/pop against a multiset reference
        @(negedge clk);
        dut.n <= 10'd0;
        model.delete();
        for (int t = 0; t < 64; t++) begin
            if (model.size() == 0 || $urandom_range(0, 9) < 6) begin
                logic [31:0] k;
                k = ktab[$urandom_range(0, 7)];
                model.push_back(k);
                exp_val(0, model_max(), model.size());
                run_op("rand push", 1'b0, k, 24, 1'b0);
            end else begin
                logic [31:0] mx;
                int          j;
                mx = model_max();
                j  = 0;
                foreach (model[i]) if (model[i] == mx) j = i;
                model.delete(j);
                if (model.size() > 0) exp_val(0, model_max(), model.size());
                else exp_dc(0, 0);
                run_op("rand pop", 1'b1, 32'h0, 24, 1'b0);
                check("rand popped max", 64'(dut.arr[model.size()]), 64'(mx));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/heap_control.md
Name: heap_control

Overview:
Max-heap engine over an internal 32-bit array. It builds a heap from preloaded contents (make_heap), inserts a key (push) and removes the maximum (pop). After each operation it streams the array out on arr_out/index for checking. It is a standalone datapath block driven by a simple start/done handshake.

Parameters:
DATA_W, 32, element width
ADDR_W, 10, width of n and index; capacity CAP = 2^ADDR_W - 1 = 1023 elements

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset
start  input  1  one-cycle request pulse, sampled in IDLE/DONE only
key  input  DATA_W  value to insert on push
op  input  1  0 = push, 1 = pop (ignored for make_heap, see below)
done  output  1  high while the block is in DONE
arr_out  output  DATA_W  arr[index] while done, else 0
n  output  ADDR_W  current element count (register)
index  output  ADDR_W  streaming read pointer

Behaviour:
- Storage: register array arr[0..CAP-1] and count register n, both named exactly so that benches can preload them hierarchically after reset. Max-heap ordering applies, parent(i) = (i-1)/2 and children 2i+1, 2i+2.
- Reset (reset==0 at a clock edge): state=IDLE, n=0, index=0, done=0, arr_out=0, built flag=0. arr contents are not cleared. Reset aborts any operation in progress.
- built flag: cleared by reset. The first accepted start after reset performs make_heap on arr[0..n-1], ignores op and key, and sets built=1. Every later start performs push or pop according to op.
- States: IDLE, BUILD, SIFT_DOWN, SIFT_UP, DONE.
- IDLE/DONE + start=1: latch op/key and leave for the operation state on the next edge. done falls on that edge. start in any other state is ignored.
- make_heap (Floyd): for i = n/2-1 down to 0, sift down from i. n<=1 goes directly to DONE.
- SIFT_DOWN step: select the largest of node and in-range children (child < n); on a tie keep the parent. If a child is larger, swap and continue at that child, else the sift ends. Each step takes at most 2 cycles.
- push: if n==CAP, no change and go to DONE. Else arr[n]=key, n=n+1, then SIFT_UP from the new slot. SIFT_UP swaps with the parent while the parent is strictly smaller and stops at the root. At most 2 cycles per level.
- pop: if n==0, no change and go to DONE. Else swap arr[0] and arr[n-1], n=n-1, then SIFT_DOWN from 0 over the new n. The removed maximum stays in arr[n] (old n-1).
- DONE: done=1. index starts at 0 on entry and increments each cycle, wrapping to 0 after n-1 (held at 0 if n==0). arr_out = arr[index], registered so it is consistent with index on the same cycle. Stays in DONE until the next start.
- Latency is not fixed cycle-exact. Bound: make_heap <= 4n+4 cycles, push/pop <= 2*ADDR_W+4 cycles.
- Widths: comparisons are unsigned DATA_W. Index arithmetic uses ADDR_W+1 bits internally to avoid overflow of 2i+2.

Test Plan:
- Preload arr = 10,20,5,6,1,8,9,4,7,2 with n=10, then pulse start (op=0) -> done; streamed index 0..9 gives 20,10,9,7,2,8,5,4,6,1; n=10.
- Then push key=15 -> done; n=11; stream gives 20,15,9,7,10,8,5,4,6,1,2.
- Then pop (op=1) -> done; n=10; stream gives 15,10,9,7,2,8,5,4,6,1; arr[10]=20.
- Pop with n=0 after the first start -> done, n stays 0, index held 0. Push with n=1023 -> done, n and array unchanged.
- Pulse start repeatedly while busy -> ignored. Assert reset mid-make_heap -> next cycle done=0, n=0, index=0, state IDLE; the following start performs make_heap.
- Equal keys: push 5 into heap {5} -> no swap, arr = 5,5. Random push/pop sequences of up to 64 ops checked against a reference max-heap model: pop order is non-increasing.
